div_share_ctrl: RTL and testbench

- Sequences one shared unsigned divider IP (AXI-stream, fixed latency) for all four EXE divide ops (div.w, mod.w, div.wu, mod.wu).
- Replaces the separate signed and unsigned divider instances.
- Converts signed operands to magnitudes, drives the IP handshakes and fixes result signs.
- Absorbs pipeline flushes by draining in-flight IP results, so no stale quotient reaches a later instruction.

---
 rtl/div_share_ctrl_pkg.sv | 12 +
 rtl/div_sign_fix.sv | 12 +
 rtl/div_share_ctrl.sv | 110 +++++++++++
 tb/tb_div_share_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_share_ctrl_pkg.sv
// div_share_ctrl_pkg: state encodings shared by the divider sequencer
package div_share_ctrl_pkg;

    typedef enum logic [4:0] {
        DIV_STATE_IDLE  = 5'b00001,
        DIV_STATE_ISSUE = 5'b00010,
        DIV_STATE_WAIT  = 5'b00100,
        DIV_STATE_DONE  = 5'b01000,
        DIV_STATE_DRAIN = 5'b10000
    } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: conditional two's-complement negate, used for operand magnitudes and result sign fixup
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    input  logic             neg,
    output logic [WIDTH-1:0] dout
);

    assign dout = neg ? -din : din;

endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: sequences one shared unsigned divider IP for signed and unsigned divide/modulo ops
module div_share_ctrl
    import div_share_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_src1,
    input  logic [WIDTH-1:0]   in_src2,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_quot,
    output logic [WIDTH-1:0]   out_rem,
    output logic [WIDTH-1:0]   ip_dividend_tdata,
    output logic               ip_dividend_tvalid,
    input  logic               ip_dividend_tready,
    output logic [WIDTH-1:0]   ip_divisor_tdata,
    output logic               ip_divisor_tvalid,
    input  logic               ip_divisor_tready,
    input  logic [2*WIDTH-1:0] ip_dout_tdata,
    input  logic               ip_dout_tvalid
);

    div_state_e state, state_n;
    logic s1, s2, dvd_done, dvs_done, cancel;
    logic dvd_hs, dvs_hs, dvd_all, dvs_all, accept;
    logic [WIDTH-1:0] mag1, mag2, quot, rem, src1_mag, src2_mag, q_fix, r_fix;

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_src1 (.din(in_src1), .neg(in_signed & in_src1[WIDTH-1]), .dout(src1_mag));
    div_sign_fix #(.WIDTH(WIDTH)) u_fix_src2 (.din(in_src2), .neg(in_signed & in_src2[WIDTH-1]), .dout(src2_mag));
    div_sign_fix #(.WIDTH(WIDTH)) u_fix_quot (.din(ip_dout_tdata[2*WIDTH-1:WIDTH]), .neg(s1 ^ s2), .dout(q_fix));
    div_sign_fix #(.WIDTH(WIDTH)) u_fix_rem  (.din(ip_dout_tdata[WIDTH-1:0]), .neg(s1), .dout(r_fix));

    assign in_ready           = (state == DIV_STATE_IDLE) && !flush;
    assign accept             = in_valid && in_ready;
    assign out_valid          = state == DIV_STATE_DONE;
    assign out_quot           = quot;
    assign out_rem            = rem;
    assign ip_dividend_tdata  = mag1;
    assign ip_divisor_tdata   = mag2;
    assign ip_dividend_tvalid = (state == DIV_STATE_ISSUE) && !dvd_done;
    assign ip_divisor_tvalid  = (state == DIV_STATE_ISSUE) && !dvs_done;
    assign dvd_hs             = ip_dividend_tvalid && ip_dividend_tready;
    assign dvs_hs             = ip_divisor_tvalid && ip_divisor_tready;
    assign dvd_all            = dvd_done || dvd_hs;
    assign dvs_all            = dvs_done || dvs_hs;

    // Next state: flush wins over in_valid/out_ready; a half-issued op must still finish issuing and be drained
    always_comb begin
        state_n = state;
        case (state)
            DIV_STATE_IDLE:  if (accept) state_n = (in_src2 == '0) ? DIV_STATE_DONE : DIV_STATE_ISSUE;
            DIV_STATE_ISSUE: if (dvd_all && dvs_all) state_n = (cancel || flush) ? DIV_STATE_DRAIN : DIV_STATE_WAIT;
                             else if (flush && !dvd_all && !dvs_all) state_n = DIV_STATE_IDLE;
            DIV_STATE_WAIT:  if (flush) state_n = ip_dout_tvalid ? DIV_STATE_IDLE : DIV_STATE_DRAIN;
                             else if (ip_dout_tvalid) state_n = DIV_STATE_DONE;
            DIV_STATE_DONE:  if (flush || out_ready) state_n = DIV_STATE_IDLE;
            DIV_STATE_DRAIN: if (ip_dout_tvalid) state_n = DIV_STATE_IDLE;
            default:         state_n = DIV_STATE_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state <= DIV_STATE_IDLE;
        else state <= state_n;
    end

    // Operand latch, per-channel handshake tracking and signed result capture
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            dvd_done <= 1'b0;
            dvs_done <= 1'b0;
            cancel   <= 1'b0;
            mag1     <= '0;
            mag2     <= '0;
            quot     <= '0;
            rem      <= '0;
        end else begin
            if (accept) begin
                s1       <= in_signed & in_src1[WIDTH-1];
                s2       <= in_signed & in_src2[WIDTH-1];
                mag1     <= src1_mag;
                mag2     <= src2_mag;
                dvd_done <= 1'b0;
                dvs_done <= 1'b0;
                cancel   <= 1'b0;
                quot     <= '1;
                rem      <= in_src1;
            end
            if (state == DIV_STATE_ISSUE) begin
                dvd_done <= dvd_all;
                dvs_done <= dvs_all;
                cancel   <= cancel | flush;
            end
            if ((state == DIV_STATE_WAIT) && ip_dout_tvalid && !flush) begin
                quot <= q_fix;
                rem  <= r_fix;
            end
        end
    end

endmodule

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl: directed bench with an arithmetic reference model and a fixed-latency divider IP model
module tb_div_share_ctrl;

    localparam int LAT = 8;

    logic clk = 1'b0, resetn = 1'b0;
    logic in_valid = 1'b0, in_signed = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] in_src1 = '0, in_src2 = '0;
    logic ip_dividend_tready = 1'b1, ip_divisor_tready = 1'b1, ip_dout_tvalid = 1'b0;
    logic [63:0] ip_dout_tdata = '0;
    logic in_ready, out_valid, ip_dividend_tvalid, ip_divisor_tvalid;
    logic [31:0] out_quot, out_rem, ip_dividend_tdata, ip_divisor_tdata;

    int checks = 0, failures = 0, cyc = 0;
    int n_dvd = 0, n_dvs = 0, n_dout = 0, tv_cnt = 0, last_dout_cyc = 0;
    logic exp_live = 1'b0;
    logic [31:0] exp_q = '0, exp_r = '0;

    div_share_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
        .in_src1(in_src1), .in_src2(in_src2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_quot(out_quot), .out_rem(out_rem),
        .ip_dividend_tdata(ip_dividend_tdata), .ip_dividend_tvalid(ip_dividend_tvalid),
        .ip_dividend_tready(ip_dividend_tready),
        .ip_divisor_tdata(ip_divisor_tdata), .ip_divisor_tvalid(ip_divisor_tvalid),
        .ip_divisor_tready(ip_divisor_tready),
        .ip_dout_tdata(ip_dout_tdata), .ip_dout_tvalid(ip_dout_tvalid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference: what the ISA says a divide op returns, in plain arithmetic
    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 0) begin
            q = 32'hFFFFFFFF;
            r = a;
        end else if (!sg) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = 32'h80000000;
            r = 0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {q, r};
    endfunction

    // Divider IP model: unsigned, fixed latency, one result pulse per operand pair
    initial begin
        logic d_hs, v_hs, pa_got, pb_got, busy;
        logic [31:0] a_s, b_s, pa, pb, fa, fb;
        int cnt;
        pa_got = 0; pb_got = 0; busy = 0; cnt = 0; pa = 0; pb = 0; fa = 0; fb = 1;
        forever begin
            @(negedge clk);
            d_hs = ip_dividend_tvalid && ip_dividend_tready;
            v_hs = ip_divisor_tvalid && ip_divisor_tready;
            a_s = ip_dividend_tdata;
            b_s = ip_divisor_tdata;
            if (ip_dividend_tvalid || ip_divisor_tvalid) tv_cnt++;
            @(posedge clk);
            #1;
            ip_dout_tvalid = 1'b0;
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    busy = 0;
                    ip_dout_tvalid = 1'b1;
                    ip_dout_tdata = (fb == 0) ? {32'hFFFFFFFF, fa} : {fa / fb, fa % fb};
                    n_dout++;
                    last_dout_cyc = cyc;
                end
            end
            if (d_hs) begin pa = a_s; pa_got = 1; n_dvd++; end
            if (v_hs) begin pb = b_s; pb_got = 1; n_dvs++; end
            if (pa_got && pb_got) begin
                chk("ip_overlap", busy, 0);
                busy = 1; cnt = LAT; fa = pa; fb = pb;
                pa_got = 0; pb_got = 0;
            end
        end
    end

    // Compare process: every cycle a result is presented it must be a live op's model value
    initial forever begin
        @(negedge clk);
        if (resetn && out_valid) begin
            chk("valid_expected", exp_live, 1);
            if (exp_live) begin
                chk("model_quot", out_quot, exp_q);
                chk("model_rem", out_rem, exp_r);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic sg, input logic [31:0] a, input logic [31:0] b, input logic live);
        int n;
        logic [63:0] m;
        n = 0;
        in_valid = 1; in_signed = sg; in_src1 = a; in_src2 = b;
        do begin @(negedge clk); n++; end while (!in_ready && n < 50);
        chk("send_accepted", in_ready, 1);
        step();
        in_valid = 0;
        if (live) begin
            m = ref_div(sg, a, b);
            exp_q = m[63:32];
            exp_r = m[31:0];
            exp_live = 1;
        end
    endtask

    task automatic get(input int hold, output logic [31:0] q, output logic [31:0] r, output int vcyc);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 100);
        chk("result_valid", out_valid, 1);
        q = out_quot; r = out_rem; vcyc = cyc;
        repeat (hold) begin
            step();
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_quot", out_quot, q);
        end
        step();
        out_ready = 1;
        step();
        out_ready = 0;
        exp_live = 0;
        @(negedge clk);
        chk("released", out_valid, 0);
        step();
    endtask

    task automatic wait_dout;
        int n0, k;
        n0 = n_dout; k = 0;
        while (n_dout == n0 && k < 40) begin @(negedge clk); k++; end
        chk("dout_seen", n_dout != n0, 1);
        step();
    endtask

    initial begin
        logic [31:0] q, r;
        int vc, t0, d0, v0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_tvalids", {ip_dividend_tvalid, ip_divisor_tvalid}, 0);
        chk("rst_results", {out_quot, out_rem}, 0);
        step();
        resetn = 1;
        step();

        send(1, 32'hFFFFFFF9, 32'd2, 1);
        get(3, q, r, vc);
        chk("neg7_div2_q", q, 32'hFFFFFFFD);
        chk("neg7_div2_r", r, 32'hFFFFFFFF);

        send(0, 32'hFFFFFFFF, 32'h10, 1);
        get(0, q, r, vc);
        chk("udiv_q", q, 32'h0FFFFFFF);
        chk("udiv_r", r, 32'hF);
        chk("valid_after_dout", vc - last_dout_cyc, 1);

        send(1, 32'h80000000, 32'hFFFFFFFF, 1);
        get(1, q, r, vc);
        chk("ovf_q", q, 32'h80000000);
        chk("ovf_r", r, 32'h0);

        t0 = tv_cnt;
        send(0, 32'h1234, 32'h0, 1);
        get(0, q, r, vc);
        chk("dz_q", q, 32'hFFFFFFFF);
        chk("dz_r", r, 32'h1234);
        chk("dz_no_tvalid", tv_cnt - t0, 0);

        ip_dividend_tready = 0; ip_divisor_tready = 0;
        send(0, 32'd50, 32'd5, 0);
        ip_dividend_tready = 1;
        @(negedge clk);
        chk("c1_dvd_tvalid", ip_dividend_tvalid, 1);
        chk("c1_dvs_tvalid", ip_divisor_tvalid, 1);
        step();
        ip_dividend_tready = 0; flush = 1;
        @(negedge clk);
        chk("c2_dvd_dropped", ip_dividend_tvalid, 0);
        chk("c2_dvs_tvalid", ip_divisor_tvalid, 1);
        step();
        flush = 0;
        @(negedge clk);
        chk("c3_dvs_tvalid", ip_divisor_tvalid, 1);
        chk("c3_in_ready", in_ready, 0);
        step();
        ip_divisor_tready = 1;
        @(negedge clk);
        chk("c4_dvs_tvalid", ip_divisor_tvalid, 1);
        step();
        ip_divisor_tready = 0;
        @(negedge clk);
        chk("drain_tvalids", {ip_dividend_tvalid, ip_divisor_tvalid}, 0);
        chk("drain_in_ready", in_ready, 0);
        chk("drain_out_valid", out_valid, 0);
        wait_dout();
        @(negedge clk);
        chk("drain_done_in_ready", in_ready, 1);
        chk("drain_done_out_valid", out_valid, 0);
        ip_dividend_tready = 1; ip_divisor_tready = 1;
        step();
        send(0, 32'd100, 32'd7, 1);
        get(0, q, r, vc);
        chk("after_drain_q", q, 32'd14);
        chk("after_drain_r", r, 32'd2);

        d0 = n_dvd; v0 = n_dvs;
        send(0, 32'd50, 32'd5, 0);
        step();
        flush = 1; in_valid = 1; in_signed = 0; in_src1 = 32'd9; in_src2 = 32'd3;
        @(negedge clk);
        chk("wait_flush_in_ready", in_ready, 0);
        step();
        flush = 0; in_valid = 0;
        @(negedge clk);
        chk("wait_drain_in_ready", in_ready, 0);
        step();
        send(0, 32'd9, 32'd3, 1);
        get(0, q, r, vc);
        chk("nine_div3_q", q, 32'd3);
        chk("nine_div3_r", r, 32'd0);
        chk("dvd_handshakes", n_dvd - d0, 2);
        chk("dvs_handshakes", n_dvs - v0, 2);

        send(0, 32'd1000, 32'd10, 0);
        step();
        step();
        resetn = 0;
        step();
        resetn = 1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        wait_dout();
        @(negedge clk);
        chk("late_dout_ignored", out_valid, 0);
        step();
        send(1, 32'hFFFFFF9C, 32'd7, 1);
        get(0, q, r, vc);
        chk("post_rst_q", q, 32'hFFFFFFF2);
        chk("post_rst_r", r, 32'hFFFFFFFE);

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
